// File: rtl/bus_mux_pipe.sv
// ---------------------------------------------------------------------------
// bus_mux_pipe
//
// Registered priority bus multiplexer.  On every enabled rising edge the
// lowest-index requesting source wins the bus.  Its data, its index and a
// valid flag appear on the outputs one cycle later.  The block also flags
// multi-driver conflicts, keeps a sticky copy of that flag, and counts
// transfers in a 16-bit saturating counter.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   clr             asynchronous active-low reset
//   src_data        NSRC packed words, source i at [i*WIDTH +: WIDTH]
//   src_out         per-source drive request
//   bus_en          sample enable; low holds the bus outputs and the counter
//   err_clr         synchronous clear of conflict_sticky
//   cnt_clr         synchronous clear of xfer_count
//   bus_out         registered winning data
//   bus_valid       bus_out holds a transfer from the previous enabled edge
//   bus_src         index of the winning source
//   conflict        two or more requests were seen at the last sample
//   conflict_sticky latched conflict, cleared by err_clr
//   xfer_count      saturating count of valid transfers
// ---------------------------------------------------------------------------
module bus_mux_pipe #(
   parameter int WIDTH      = 32,
   parameter int NSRC       = 24,
   parameter int SELW       = $clog2(NSRC),
   parameter bit HOLD_EMPTY = 1'b0
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NSRC*WIDTH-1:0]   src_data,
   input  logic [NSRC-1:0]         src_out,
   input  logic                    bus_en,
   input  logic                    err_clr,
   input  logic                    cnt_clr,
   output logic [WIDTH-1:0]        bus_out,
   output logic                    bus_valid,
   output logic [SELW-1:0]         bus_src,
   output logic                    conflict,
   output logic                    conflict_sticky,
   output logic [15:0]             xfer_count
);

   localparam logic [NSRC-1:0] ONE = {{(NSRC-1){1'b0}}, 1'b1};

   logic [SELW-1:0]  win_idx;
   logic [WIDTH-1:0] win_data;
   logic             any_req;
   logic             multi_req;
   logic             take;

   // Scan from the top down so the lowest asserted index is the last writer.
   always_comb begin
      win_idx  = '0;
      win_data = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (src_out[i]) begin
            win_idx  = SELW'(i);
            win_data = src_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign any_req   = |src_out;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_req = |(src_out & (src_out - ONE));
   assign take      = bus_en & any_req;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         bus_out   <= '0;
         bus_valid <= 1'b0;
         bus_src   <= '0;
         conflict  <= 1'b0;
      end else if (bus_en) begin
         conflict <= multi_req;
         if (any_req) begin
            bus_out   <= win_data;
            bus_valid <= 1'b1;
            bus_src   <= win_idx;
         end else begin
            bus_valid <= 1'b0;
            bus_src   <= '0;
            if (!HOLD_EMPTY) begin
               bus_out <= '0;
            end
         end
      end
   end

   // A new conflict takes priority over err_clr on the same edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         conflict_sticky <= 1'b0;
      end else if (bus_en && multi_req) begin
         conflict_sticky <= 1'b1;
      end else if (err_clr) begin
         conflict_sticky <= 1'b0;
      end
   end

   // cnt_clr works regardless of bus_en; a same-edge transfer is still counted.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         xfer_count <= '0;
      end else if (cnt_clr) begin
         xfer_count <= {15'd0, take};
      end else if (take && (xfer_count != 16'hFFFF)) begin
         xfer_count <= xfer_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_bus_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_bus_mux_pipe
//
// Scoreboard bench for bus_mux_pipe.  The driver applies one set of inputs
// per cycle on the falling edge, advances a behavioural model of the bus and
// queues the outputs expected after the next rising edge.  An independent
// monitor pops one entry shortly after every rising edge and compares it
// against the DUT.
// ---------------------------------------------------------------------------
module tb_bus_mux_pipe;

   localparam int WIDTH      = 32;
   localparam int NSRC       = 24;
   localparam int SELW       = $clog2(NSRC);
   localparam bit HOLD_EMPTY = 1'b0;

   logic                  clk = 1'b0;
   logic                  clr;
   logic [NSRC*WIDTH-1:0] src_data;
   logic [NSRC-1:0]       src_out;
   logic                  bus_en;
   logic                  err_clr;
   logic                  cnt_clr;
   logic [WIDTH-1:0]      bus_out;
   logic                  bus_valid;
   logic [SELW-1:0]       bus_src;
   logic                  conflict;
   logic                  conflict_sticky;
   logic [15:0]           xfer_count;

   bus_mux_pipe #(
      .WIDTH      (WIDTH),
      .NSRC       (NSRC),
      .SELW       (SELW),
      .HOLD_EMPTY (HOLD_EMPTY)
   ) dut (
      .clk             (clk),
      .clr             (clr),
      .src_data        (src_data),
      .src_out         (src_out),
      .bus_en          (bus_en),
      .err_clr         (err_clr),
      .cnt_clr         (cnt_clr),
      .bus_out         (bus_out),
      .bus_valid       (bus_valid),
      .bus_src         (bus_src),
      .conflict        (conflict),
      .conflict_sticky (conflict_sticky),
      .xfer_count      (xfer_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] out;
      logic        valid;
      int          src;
      logic        conf;
      logic        sticky;
      int          cnt;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] sdata [NSRC];

   int          checks = 0;
   int          errors = 0;

   // model state
   logic [31:0] m_out    = '0;
   logic        m_valid  = 1'b0;
   int          m_src    = 0;
   logic        m_conf   = 1'b0;
   logic        m_sticky = 1'b0;
   int          m_cnt    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic [NSRC-1:0] so, input logic en,
                               input logic ec, input logic cc, input logic rst_n);
      int n;
      int win;
      if (!rst_n) begin
         m_out = '0; m_valid = 1'b0; m_src = 0;
         m_conf = 1'b0; m_sticky = 1'b0; m_cnt = 0;
      end else begin
         n   = $countones(so);
         win = -1;
         for (int i = 0; i < NSRC; i++)
            if (so[i] && win < 0) win = i;
         if (en) begin
            if (n > 0) begin
               m_out = sdata[win]; m_valid = 1'b1; m_src = win;
            end else begin
               m_valid = 1'b0; m_src = 0;
               if (!HOLD_EMPTY) m_out = '0;
            end
            m_conf = (n >= 2);
         end
         if (en && n >= 2)   m_sticky = 1'b1;
         else if (ec)        m_sticky = 1'b0;
         if (cc)                          m_cnt = (en && n > 0) ? 1 : 0;
         else if (en && n > 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic step(input logic [NSRC-1:0] so, input logic en, input logic ec,
                       input logic cc, input logic rst_n);
      exp_t e;
      @(negedge clk);
      src_out = so; bus_en = en; err_clr = ec; cnt_clr = cc; clr = rst_n;
      for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = sdata[i];
      model_update(so, en, ec, cc, rst_n);
      e.out = m_out; e.valid = m_valid; e.src = m_src;
      e.conf = m_conf; e.sticky = m_sticky; e.cnt = m_cnt;
      sb_q.push_back(e);
      if (!rst_n) begin
         // reset must take effect without waiting for a clock edge
         #1;
         chk("async_bus_out",    bus_out,                 32'd0);
         chk("async_bus_valid",  32'(bus_valid),          32'd0);
         chk("async_bus_src",    32'(bus_src),            32'd0);
         chk("async_conflict",   32'(conflict),           32'd0);
         chk("async_sticky",     32'(conflict_sticky),    32'd0);
         chk("async_xfer_count", 32'(xfer_count),         32'd0);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("bus_out",         bus_out,              e.out);
            chk("bus_valid",       32'(bus_valid),       32'(e.valid));
            chk("bus_src",         32'(bus_src),         32'(e.src));
            chk("conflict",        32'(conflict),        32'(e.conf));
            chk("conflict_sticky", 32'(conflict_sticky), 32'(e.sticky));
            chk("xfer_count",      32'(xfer_count),      32'(e.cnt));
         end
      end
   end

   function automatic logic [NSRC-1:0] rand_req();
      logic [NSRC-1:0] r;
      r = '0;
      case ($urandom_range(0, 3))
         0: r = '0;
         1: r[$urandom_range(0, NSRC-1)] = 1'b1;
         2: r = NSRC'($urandom);
         default: begin
            r[$urandom_range(0, NSRC-1)] = 1'b1;
            r[$urandom_range(0, NSRC-1)] = 1'b1;
         end
      endcase
      return r;
   endfunction

   task automatic rand_data();
      for (int i = 0; i < NSRC; i++) sdata[i] = $urandom;
   endtask

   initial begin
      logic [NSRC-1:0] so;
      int              wait_cycles;

      clr = 1'b0; src_out = '0; bus_en = 1'b0; err_clr = 1'b0; cnt_clr = 1'b0;
      src_data = '0;
      rand_data();

      // held in reset: requests are ignored
      repeat (3) step(NSRC'(24'h00FF00), 1'b1, 1'b0, 1'b0, 1'b0);

      // single source, first sample right after release
      rand_data();
      sdata[5] = 32'hDEADBEEF;
      step(NSRC'(1) << 5, 1'b1, 1'b0, 1'b0, 1'b1);

      // conflict between sources 3 and 17, sticky survives until err_clr
      so = '0; so[3] = 1'b1; so[17] = 1'b1;
      step(so, 1'b1, 1'b0, 1'b0, 1'b1);
      step('0, 1'b1, 1'b0, 1'b0, 1'b1);
      step('0, 1'b1, 1'b0, 1'b0, 1'b1);
      step('0, 1'b1, 1'b1, 1'b0, 1'b1);

      // conflict and err_clr on the same edge keeps sticky set
      step(so, 1'b1, 1'b1, 1'b0, 1'b1);

      // idle bus after a transfer
      sdata[7] = 32'h12345678;
      step(NSRC'(1) << 7, 1'b1, 1'b0, 1'b0, 1'b1);
      step('0, 1'b1, 1'b0, 1'b0, 1'b1);

      // enable stall with changing requests; clears still act
      step(NSRC'(3), 1'b1, 1'b0, 1'b0, 1'b1);
      step(rand_req(), 1'b0, 1'b0, 1'b0, 1'b1);
      step(rand_req(), 1'b0, 1'b1, 1'b0, 1'b1);
      step(NSRC'(1) << 9, 1'b0, 1'b0, 1'b1, 1'b1);
      step(NSRC'(1) << 9, 1'b1, 1'b0, 1'b0, 1'b1);

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         rand_data();
         step(rand_req(), ($urandom_range(0, 99) < 85),
              ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 3),
              ($urandom_range(0, 99) >= 1));
      end
      step('0, 1'b1, 1'b0, 1'b0, 1'b1);

      // async reset mid-cycle while a transfer is on the bus
      rand_data();
      step(NSRC'(1) << 2, 1'b1, 1'b0, 1'b0, 1'b1);
      step(NSRC'(1) << 2, 1'b1, 1'b0, 1'b0, 1'b0);
      step(NSRC'(1) << 4, 1'b1, 1'b0, 1'b0, 1'b1);
      step('0, 1'b1, 1'b0, 1'b0, 1'b1);

      // counter saturation: 65535 transfers, one more, then clear with a transfer
      step(NSRC'(1), 1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 65534; k++) step(NSRC'(1), 1'b1, 1'b0, 1'b0, 1'b1);
      step(NSRC'(1) << 1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(NSRC'(1) << 1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(NSRC'(1) << 6, 1'b1, 1'b0, 1'b1, 1'b1);
      step('0, 1'b1, 1'b0, 1'b1, 1'b1);

      // drain the scoreboard with a bounded wait
      wait_cycles = 0;
      while (sb_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         #2;
         wait_cycles++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0 entries left", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
